mux_scan_n: RTL and testbench
=============================

Name: mux_scan_n

Overview:
- Parametrised, registered N-channel multiplexer; successor to the combinational 4-to-1 mux.
- Two modes:
  - DIRECT: an external select chooses the channel.
  - SCAN: an internal counter cycles through all channels round-robin, holding each for a programmable dwell.
- Sits between multi-channel sources and single-wide consumers, e.g. time-multiplexed display or serial drivers.
- Output is registered and tagged with the active channel index.

Parameters:
- WIDTH, 1, bits per channel.
- CHANNELS, 4, number of input channels; must be >= 2.
- SEL_W, $clog2(CHANNELS), width of the select and channel index. Derived; do not override.
- DWELL, 1, enabled cycles spent on each channel in SCAN mode; must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- data_in  input  CHANNELS*WIDTH  packed channels; channel k = data_in[k*WIDTH +: WIDTH], with channel 0 in the LSBs.
- en  input  1  advance/sample enable; when low, all state and outputs hold.
- mode  input  1  0 = DIRECT, 1 = SCAN.
- sel  input  SEL_W  channel select, used in DIRECT mode only.
- out  output  WIDTH  registered selected channel data.
- out_valid  output  1  high when out holds a legal channel sample.
- chan_out  output  SEL_W  index of the channel currently presented on out.
- wrap  output  1  one-cycle pulse when the SCAN pointer wraps from CHANNELS-1 to 0.

Behaviour:
- Reset, sampled on a clk edge with reset = 1:
  - out = 0, out_valid = 0, chan_out = 0, wrap = 0.
  - Internal ptr = 0, dwell_cnt = 0, state = IDLE.
  - Reset overrides en and mode in the same cycle, including mid-scan.
- States and transitions:
  - IDLE: on en = 1, go to DIRECT if mode = 0, else SCAN. The first sample is taken on that same edge.
  - DIRECT: on en = 1 with mode = 1, go to SCAN, with ptr = 0, dwell_cnt = 0, and channel 0 sampled on that edge.
  - SCAN: on en = 1 with mode = 0, go to DIRECT, sampling sel on that edge. ptr and dwell_cnt are cleared.
- DIRECT, per enabled edge:
  - out <= channel[sel], chan_out <= sel, out_valid <= 1.
  - If sel >= CHANNELS (possible when CHANNELS is not a power of 2): out <= 0, out_valid <= 0, chan_out <= sel.
  - Latency: 1 clk edge from sel/data_in to out.
  - wrap is always 0 in DIRECT.
- SCAN, per enabled edge:
  - out <= channel[ptr], chan_out <= ptr, out_valid <= 1.
  - If dwell_cnt == DWELL-1: dwell_cnt <= 0 and ptr advances. If ptr == CHANNELS-1, ptr <= 0 and wrap <= 1; otherwise ptr <= ptr+1.
  - Else dwell_cnt <= dwell_cnt+1.
  - wrap is high for exactly one cycle, on the edge after the final dwell cycle of channel CHANNELS-1 is sampled.
- en = 0: out, out_valid, chan_out, ptr and dwell_cnt hold. wrap drops to 0.
- data_in changes mid-dwell are reflected on the next enabled edge; the registered value tracks live data for the dwelling channel.
- Mode change and wrap on the same edge: the mode change wins; wrap = 0, ptr = 0.
- Width rule: out is exactly WIDTH bits. No sign or extension logic.

Test Plan:
- Reset with WIDTH=1, CHANNELS=4, data_in=4'b1010 (A=0, B=1, C=0, D=1): hold reset for 2 clk -> out=0, out_valid=0, chan_out=0, wrap=0.
- DIRECT, en=1, sel=3 -> one edge later out=1, chan_out=3, out_valid=1. Then sel=2 -> out=0, chan_out=2.
- SCAN, DWELL=1, en held high, data_in=4'b1010:
  - out sequence 0,1,0,1,0 with chan_out 0,1,2,3,0.
  - wrap=1 only in the cycle where chan_out returns to 0.
- SCAN with DWELL=3, WIDTH=8, CHANNELS=3, data_in={8'hC3,8'hB2,8'hA1}:
  - each of A1, B2, C3 is held for 3 cycles.
  - wrap pulses once per 9 cycles.
  - Drop en for 2 cycles mid-dwell -> outputs frozen, and the remaining dwell count resumes.
- Boundary cases:
  - CHANNELS=3, DIRECT, sel=3 -> out=0, out_valid=0.
  - Switch to SCAN on the same edge the pointer would wrap -> chan_out=0, wrap=0.
  - Assert reset mid-scan at chan_out=2 -> next edge out=0, chan_out=0, IDLE.

Source files
------------

// File: rtl/mux_scan_n.sv
// rtl/mux_scan_n.sv - registered N-channel mux with direct select and round-robin scan modes
module mux_scan_n #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS),
    parameter int DWELL    = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic                      en,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out,
    output logic                      out_valid,
    output logic [SEL_W-1:0]          chan_out,
    output logic                      wrap
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0]    DWELL_LAST = DW'(DWELL - 1);
    localparam logic [SEL_W-1:0] CH_LAST    = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W:0]   CH_COUNT   = (SEL_W + 1)'(CHANNELS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_out;
    logic               r_valid;
    logic [SEL_W-1:0]   r_chan;
    logic               r_wrap;
    logic [SEL_W-1:0]   r_ptr;
    logic [DW-1:0]      r_dwell;

    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_out_nxt;
    logic               w_valid_nxt;
    logic [SEL_W-1:0]   w_chan_nxt;
    logic               w_wrap_nxt;
    logic [SEL_W-1:0]   w_ptr_nxt;
    logic [DW-1:0]      w_dwell_nxt;

    logic [WIDTH-1:0]   w_sel_data;
    logic [WIDTH-1:0]   w_ptr_data;
    logic               w_sel_ok;

    // Loop-based mux so an out-of-range sel simply selects nothing.
    always_comb begin
        w_sel_data = '0;
        w_ptr_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (int'(sel) == k)   w_sel_data = data_in[k*WIDTH +: WIDTH];
            if (int'(r_ptr) == k) w_ptr_data = data_in[k*WIDTH +: WIDTH];
        end
    end

    assign w_sel_ok = ({1'b0, sel} < CH_COUNT);

    // ptr/dwell are held at zero outside SCAN, so entering SCAN is an ordinary
    // scan step from channel 0. A SCAN edge that finds ptr=0, dwell=0 must
    // follow a wrap, which is exactly when wrap is presented.
    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_valid_nxt = r_valid;
        w_chan_nxt  = r_chan;
        w_wrap_nxt  = 1'b0;
        w_ptr_nxt   = r_ptr;
        w_dwell_nxt = r_dwell;
        if (en) begin
            if (!mode) begin
                w_state_nxt = DIRECT;
                w_chan_nxt  = sel;
                w_valid_nxt = w_sel_ok;
                w_out_nxt   = w_sel_ok ? w_sel_data : '0;
                w_ptr_nxt   = '0;
                w_dwell_nxt = '0;
            end else begin
                w_state_nxt = SCAN;
                w_chan_nxt  = r_ptr;
                w_valid_nxt = 1'b1;
                w_out_nxt   = w_ptr_data;
                w_wrap_nxt  = (r_state == SCAN) && (r_ptr == '0) && (r_dwell == '0);
                if (r_dwell == DWELL_LAST) begin
                    w_dwell_nxt = '0;
                    w_ptr_nxt   = (r_ptr == CH_LAST) ? '0 : r_ptr + 1'b1;
                end else begin
                    w_dwell_nxt = r_dwell + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_chan  <= '0;
            r_wrap  <= 1'b0;
            r_ptr   <= '0;
            r_dwell <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            r_valid <= w_valid_nxt;
            r_chan  <= w_chan_nxt;
            r_wrap  <= w_wrap_nxt;
            r_ptr   <= w_ptr_nxt;
            r_dwell <= w_dwell_nxt;
        end
    end

    assign out       = r_out;
    assign out_valid = r_valid;
    assign chan_out  = r_chan;
    assign wrap      = r_wrap;

endmodule

// File: tb/tb_mux_scan_n.sv
// tb/tb_mux_scan_n.sv - scoreboard bench for mux_scan_n in two parameter configurations
module tb_mux_scan_n;

    typedef struct {
        int out;
        int valid;
        int chan;
        int wrap;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Configuration A: WIDTH=1, CHANNELS=4, DWELL=1
    logic        a_rst, a_en, a_mode;
    logic [3:0]  a_data;
    logic [1:0]  a_sel;
    logic [0:0]  a_out;
    logic        a_valid, a_wrap;
    logic [1:0]  a_chan;

    // Configuration B: WIDTH=8, CHANNELS=3, DWELL=3
    logic        b_rst, b_en, b_mode;
    logic [23:0] b_data;
    logic [1:0]  b_sel;
    logic [7:0]  b_out;
    logic        b_valid, b_wrap;
    logic [1:0]  b_chan;

    mux_scan_n #(.WIDTH(1), .CHANNELS(4), .DWELL(1)) u_a (
        .clk(clk), .reset(a_rst), .data_in(a_data), .en(a_en), .mode(a_mode), .sel(a_sel),
        .out(a_out), .out_valid(a_valid), .chan_out(a_chan), .wrap(a_wrap)
    );

    mux_scan_n #(.WIDTH(8), .CHANNELS(3), .DWELL(3)) u_b (
        .clk(clk), .reset(b_rst), .data_in(b_data), .en(b_en), .mode(b_mode), .sel(b_sel),
        .out(b_out), .out_valid(b_valid), .chan_out(b_chan), .wrap(b_wrap)
    );

    int n_vec = 0;
    int n_bad = 0;
    exp_t qa[$];
    exp_t qb[$];

    exp_t ea = '{0, 0, 0, 0};
    exp_t eb = '{0, 0, 0, 0};
    bit   a_in_scan = 0, b_in_scan = 0;
    int   a_idx = 0, b_idx = 0;

    // Reference: idx counts enabled scan samples since entering SCAN; the
    // channel is idx/DWELL mod CHANNELS and every full lap re-entering channel 0 wraps.
    task automatic model_step(input int ch, input int dw, input int w, input logic [31:0] data,
                              input bit rst, input bit en, input bit mode, input int sel,
                              inout exp_t e, inout bit in_scan, inout int idx);
        int c;
        if (rst) begin
            e = '{0, 0, 0, 0};
            in_scan = 0;
            idx = 0;
        end else if (!en) begin
            e.wrap = 0;
        end else if (!mode) begin
            e.chan  = sel;
            e.valid = (sel < ch) ? 1 : 0;
            e.out   = (sel < ch) ? int'((data >> (sel * w)) & ((32'd1 << w) - 1)) : 0;
            e.wrap  = 0;
            in_scan = 0;
            idx = 0;
        end else begin
            if (!in_scan) idx = 0;
            c = (idx / dw) % ch;
            e.wrap  = (in_scan && (idx % (dw * ch)) == 0) ? 1 : 0;
            e.chan  = c;
            e.valid = 1;
            e.out   = int'((data >> (c * w)) & ((32'd1 << w) - 1));
            idx++;
            in_scan = 1;
        end
    endtask

    task automatic drive_a(input bit rst, input bit en, input bit mode, input int sel, input logic [3:0] data);
        @(negedge clk);
        a_rst = rst; a_en = en; a_mode = mode; a_sel = sel[1:0]; a_data = data;
        @(posedge clk);
        model_step(4, 1, 1, {28'd0, data}, rst, en, mode, sel, ea, a_in_scan, a_idx);
        qa.push_back(ea);
    endtask

    task automatic drive_b(input bit rst, input bit en, input bit mode, input int sel, input logic [23:0] data);
        @(negedge clk);
        b_rst = rst; b_en = en; b_mode = mode; b_sel = sel[1:0]; b_data = data;
        @(posedge clk);
        model_step(3, 3, 8, {8'd0, data}, rst, en, mode, sel, eb, b_in_scan, b_idx);
        qb.push_back(eb);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            n_vec++;
            if (int'(a_out) != e.out || int'(a_valid) != e.valid || int'(a_chan) != e.chan || int'(a_wrap) != e.wrap) begin
                n_bad++;
                $display("FAIL cfgA t=%0t got out=%0d valid=%0d chan=%0d wrap=%0d expected out=%0d valid=%0d chan=%0d wrap=%0d",
                         $time, a_out, a_valid, a_chan, a_wrap, e.out, e.valid, e.chan, e.wrap);
            end
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            n_vec++;
            if (int'(b_out) != e.out || int'(b_valid) != e.valid || int'(b_chan) != e.chan || int'(b_wrap) != e.wrap) begin
                n_bad++;
                $display("FAIL cfgB t=%0t got out=%0h valid=%0d chan=%0d wrap=%0d expected out=%0h valid=%0d chan=%0d wrap=%0d",
                         $time, b_out, b_valid, b_chan, b_wrap, e.out, e.valid, e.chan, e.wrap);
            end
        end
    end

    initial begin
        a_rst = 1; a_en = 0; a_mode = 0; a_sel = 0; a_data = 4'b1010;
        b_rst = 1; b_en = 0; b_mode = 0; b_sel = 0; b_data = 24'hC3B2A1;

        // Config A: reset, direct selects, scan laps, mode switch on a would-wrap edge
        drive_a(1, 0, 0, 0, 4'b1010);
        drive_a(1, 0, 0, 0, 4'b1010);
        drive_a(0, 1, 0, 3, 4'b1010);
        drive_a(0, 1, 0, 2, 4'b1010);
        drive_a(1, 0, 0, 0, 4'b1010);
        for (int i = 0; i < 10; i++) drive_a(0, 1, 1, 0, 4'b1010);
        drive_a(0, 1, 1, 0, 4'b1010);
        drive_a(0, 1, 1, 0, 4'b1010);
        drive_a(0, 1, 0, 1, 4'b1010);
        drive_a(0, 1, 1, 0, 4'b1010);
        drive_a(0, 1, 0, 0, 4'b0110);
        for (int i = 0; i < 300; i++)
            drive_a(($urandom_range(0, 19) == 0), ($urandom_range(0, 4) != 0), $urandom_range(0, 1),
                    $urandom_range(0, 3), 4'($urandom));

        // Config B: dwell of 3, frozen mid-dwell, invalid select, reset mid-scan
        drive_b(1, 0, 0, 0, 24'hC3B2A1);
        drive_b(1, 0, 0, 0, 24'hC3B2A1);
        for (int i = 0; i < 20; i++) drive_b(0, 1, 1, 0, 24'hC3B2A1);
        drive_b(0, 0, 1, 0, 24'h123456);
        drive_b(0, 0, 1, 0, 24'h123456);
        for (int i = 0; i < 12; i++) drive_b(0, 1, 1, 0, 24'hC3B2A1);
        drive_b(0, 1, 0, 3, 24'hC3B2A1);
        drive_b(0, 1, 0, 1, 24'hC3B2A1);
        for (int i = 0; i < 7; i++) drive_b(0, 1, 1, 0, 24'hC3B2A1);
        drive_b(1, 1, 1, 0, 24'hC3B2A1);
        drive_b(0, 0, 1, 0, 24'hC3B2A1);
        for (int i = 0; i < 400; i++)
            drive_b(($urandom_range(0, 29) == 0), ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) != 0),
                    $urandom_range(0, 3), 24'($urandom));

        repeat (3) @(posedge clk);
        if (qa.size() != 0 || qb.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d/%0d pending expected 0/0", qa.size(), qb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
